param_bist_controller: RTL and testbench
========================================

Name: param_bist_controller

Overview:
Self-running, parametrised built-in self-test engine for a HALF_W x HALF_W unsigned multiplier behind a 2*HALF_W-bit scan chain. An LFSR generates patterns that are shifted into the chain. Each product is captured and then shifted out. A serial-input signature register (SISR) compresses the scan-out stream. An FSM sequences NUM_PATTERNS patterns, then reports the signature and pass/fail against a golden value. Replaces the manually driven scan_en flow with autonomous start/done control.

Parameters:
- HALF_W, 4: operand width; chain length N = 2*HALF_W.
- NUM_PATTERNS, 16: patterns per run, >= 1.
- SEED, 8'h5A (N bits): LFSR load value. A value of 0 is replaced by 1.
- LFSR_TAPS, 8'hB8 (N bits): generator feedback mask.
- SISR_TAPS, 8'hB8 (N bits): signature feedback mask.
- GOLDEN, 0 (N bits): expected final signature.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: asynchronous active-high reset.
- start, in, 1: begin run; sampled only in IDLE and DONE.
- abort, in, 1: synchronous return to IDLE from any state.
- busy, out, 1: high in SHIFT, CAPTURE and UNLOAD.
- done, out, 1: high in DONE.
- pass, out, 1: in DONE, high when signature == GOLDEN; 0 elsewhere.
- signature, out, N: current SISR contents.
- scan_out, out, 1: chain[N-1], observable at all times.

Behaviour:
- Reset (asynchronous): state=IDLE; busy/done/pass=0; chain=0; signature=0; LFSR=SEED; counters=0.
- LFSR: scan_in = lfsr[N-1]. On advance, lfsr <= {lfsr[N-2:0], ^(lfsr & LFSR_TAPS)}. Consequently the first N bits shifted in after a load equal the load value, MSB first.
- Chain shift: chain <= {chain[N-2:0], scan_in}. Operands are a = chain[N-1:HALF_W] and b = chain[HALF_W-1:0].
- Chain capture: chain <= a*b, unsigned, full 2*HALF_W bits, no truncation.
- SISR absorb: sig <= {sig[N-2:0], ^(sig & SISR_TAPS) ^ scan_out}, where scan_out is the pre-shift chain[N-1].
- IDLE:
  - start -> SHIFT; in the same edge, chain<=0, sig<=0, lfsr<=SEED, bit_cnt<=0, pat_cnt<=0.
- SHIFT: N cycles.
  - Each cycle: chain shifts, LFSR advances, SISR absorbs.
  - After bit_cnt==N-1 -> CAPTURE.
- CAPTURE: 1 cycle.
  - Chain captures; LFSR and SISR hold.
  - If pat_cnt==NUM_PATTERNS-1 -> UNLOAD; else pat_cnt++ and -> SHIFT with bit_cnt=0.
- UNLOAD: N cycles.
  - Chain shifts with scan_in forced 0; LFSR holds; SISR absorbs.
  - Then -> DONE.
- DONE:
  - done=1 and pass registered from the final signature. Signature holds.
  - start -> restart exactly as from IDLE. Otherwise stay in DONE.
- Run length: start edge to first DONE cycle = NUM_PATTERNS*(N+1)+N cycles (152 at defaults).
- busy rises the cycle after the start edge. done rises the cycle after the last UNLOAD shift.
- Boundary conditions:
  - start while busy: ignored.
  - abort: wins over start and all transitions; -> IDLE, clears chain, signature and counters, lfsr<=SEED.
  - abort in IDLE: no effect beyond the clears.
  - rst mid-run: immediate return to reset values; no partial done or pass.
  - NUM_PATTERNS=1: SHIFT, CAPTURE, UNLOAD, DONE.
  - Counter widths are $clog2 of N and NUM_PATTERNS, min 1. Terminal-count compares are exact; no wrap.

Decomposition:
- Package bist_pkg holds:
  - state enum: IDLE, SHIFT, CAPTURE, UNLOAD, DONE;
  - default tap constant 8'hB8;
  - function for the feedback reduction.
- Sub-module bist_lfsr(N, TAPS, with serial-input enable) is instantiated twice: as the pattern generator with serial input tied 0, and as the SISR.
- FSM, counters, chain and multiplier live in param_bist_controller.

Test Plan:
- Defaults, pulse start: after the 8 SHIFT cycles chain==8'h5A (a=5, b=10); after CAPTURE chain==8'h32. The next 8 scan_out bits are 0,0,1,1,0,0,1,0.
- Defaults, full run: done asserts exactly 152 cycles after the start edge. signature matches a bench reference model. With GOLDEN set to that value pass==1; with GOLDEN+1, pass==0.
- NUM_PATTERNS=1, SEED=8'hFF: chain 8'hFF -> capture 8'hE1 (15*15=225). done after 17 cycles; signature equals the model of absorbing 0x00 then 0xE1.
- Run twice back-to-back by pulsing start in DONE: identical signature and cycle count both times. A start pulse during SHIFT changes nothing.
- abort asserted in cycle 40: next cycle state IDLE, busy=0, signature=0, chain=0. A subsequent start reproduces the full-run signature.
- rst pulsed asynchronously mid-UNLOAD, off clock edge: all outputs 0 immediately. done never asserts until a new start.

Source files
------------

// File: rtl/bist_pkg.sv
// Shared types and helpers for the parametrised scan BIST engine.
//   state_e      : sequencer states
//   DEFAULT_TAPS : default feedback mask for 8-bit generator/SISR
//   feedback()   : XOR reduction of a register masked by its taps
package bist_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    UNLOAD  = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam logic [7:0] DEFAULT_TAPS = 8'hB8;

  // Widest register the reduction helper supports; callers zero-extend.
  localparam int unsigned FB_MAX_W = 64;

  function automatic logic feedback(input logic [FB_MAX_W-1:0] vec,
                                    input logic [FB_MAX_W-1:0] taps);
    return ^(vec & taps);
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Shift register with masked XOR feedback and an optional serial input.
// With sin tied low it is a pattern generator; with sin driven it is a SISR.
//   clk, rst : clock, async active-high reset (loads LOAD_VAL)
//   load     : synchronous reload of LOAD_VAL (wins over en)
//   en       : advance one step
//   sin      : serial input XORed into the feedback bit
//   q        : current register contents
//   q_nxt_c  : combinational next-state value
module bist_lfsr
  import bist_pkg::*;
#(
  parameter int unsigned  N        = 8,
  parameter logic [N-1:0] TAPS     = N'(DEFAULT_TAPS),
  parameter logic [N-1:0] LOAD_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic         sin,
  output logic [N-1:0] q,
  output logic [N-1:0] q_nxt_c
);

  logic [N-1:0] q_q;
  logic [N-1:0] q_d;

  // Next state: reload, shift-left with feedback, or hold.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = LOAD_VAL;
    end else if (en) begin
      q_d = {q_q[N-2:0], feedback(FB_MAX_W'(q_q), FB_MAX_W'(TAPS)) ^ sin};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= LOAD_VAL;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign q_nxt_c = q_d;

endmodule

// File: rtl/param_bist_controller.sv
// Autonomous BIST for a HALF_W x HALF_W unsigned multiplier behind a
// 2*HALF_W-bit scan chain: LFSR patterns are shifted in, the product is
// captured, and the scan-out stream is compressed in a SISR.
//   clk, rst  : clock, async active-high reset
//   start     : begin a run (honoured only in IDLE and DONE)
//   abort     : synchronous return to IDLE from any state
//   busy      : high in SHIFT, CAPTURE, UNLOAD
//   done      : high in DONE
//   pass      : in DONE, signature matches GOLDEN
//   signature : current SISR contents
//   scan_out  : chain MSB
module param_bist_controller
  import bist_pkg::*;
#(
  parameter int unsigned           HALF_W       = 4,
  parameter int unsigned           NUM_PATTERNS = 16,
  parameter logic [2*HALF_W-1:0]   SEED         = (2*HALF_W)'(8'h5A),
  parameter logic [2*HALF_W-1:0]   LFSR_TAPS    = (2*HALF_W)'(DEFAULT_TAPS),
  parameter logic [2*HALF_W-1:0]   SISR_TAPS    = (2*HALF_W)'(DEFAULT_TAPS),
  parameter logic [2*HALF_W-1:0]   GOLDEN       = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [2*HALF_W-1:0]   signature,
  output logic                  scan_out
);

  localparam int unsigned N     = 2 * HALF_W;
  localparam int unsigned BIT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned PAT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;

  // An all-zero seed would lock the generator at zero.
  localparam logic [N-1:0]     SEED_EFF = (SEED == '0) ? N'(1) : SEED;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

  state_e             state_q,   state_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [PAT_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic [N-1:0]       chain_q,   chain_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic               pass_q,    pass_d;

  logic               restart_c;
  logic               gen_adv_c;
  logic               sig_adv_c;
  logic               scan_in_c;
  logic [HALF_W-1:0]  op_a_c;
  logic [HALF_W-1:0]  op_b_c;
  logic [N-1:0]       prod_c;
  logic [N-1:0]       gen_q;
  logic [N-1:0]       gen_nxt_c;
  logic [N-1:0]       sig_q;
  logic [N-1:0]       sig_nxt_c;
  logic               unused_gen;

  // Pattern generator: serial input unused.
  bist_lfsr #(
    .N        (N),
    .TAPS     (LFSR_TAPS),
    .LOAD_VAL (SEED_EFF)
  ) u_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (restart_c),
    .en      (gen_adv_c),
    .sin     (1'b0),
    .q       (gen_q),
    .q_nxt_c (gen_nxt_c)
  );

  // Signature register absorbing the pre-shift chain MSB.
  bist_lfsr #(
    .N        (N),
    .TAPS     (SISR_TAPS),
    .LOAD_VAL ('0)
  ) u_sisr (
    .clk     (clk),
    .rst     (rst),
    .load    (restart_c),
    .en      (sig_adv_c),
    .sin     (chain_q[N-1]),
    .q       (sig_q),
    .q_nxt_c (sig_nxt_c)
  );

  assign unused_gen = ^{gen_q[N-2:0], gen_nxt_c};

  assign scan_in_c = gen_q[N-1];
  assign op_a_c    = chain_q[N-1:HALF_W];
  assign op_b_c    = chain_q[HALF_W-1:0];
  assign prod_c    = N'(op_a_c) * N'(op_b_c);

  // Sequencer: next state, counters, chain and engine enables.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    pat_cnt_d = pat_cnt_q;
    chain_d   = chain_q;
    restart_c = 1'b0;
    gen_adv_c = 1'b0;
    sig_adv_c = 1'b0;

    if (abort) begin
      state_d   = IDLE;
      restart_c = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d   = SHIFT;
            restart_c = 1'b1;
          end
        end
        SHIFT: begin
          chain_d   = {chain_q[N-2:0], scan_in_c};
          gen_adv_c = 1'b1;
          sig_adv_c = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = CAPTURE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        CAPTURE: begin
          chain_d = prod_c;
          if (pat_cnt_q == PAT_LAST) begin
            state_d = UNLOAD;
          end else begin
            pat_cnt_d = pat_cnt_q + PAT_W'(1);
            state_d   = SHIFT;
          end
        end
        UNLOAD: begin
          chain_d   = {chain_q[N-2:0], 1'b0};
          sig_adv_c = 1'b1;
          if (bit_cnt_q == BIT_LAST) begin
            state_d   = DONE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    if (restart_c) begin
      chain_d   = '0;
      bit_cnt_d = '0;
      pat_cnt_d = '0;
    end

    // Status flags follow the state being entered so they line up with it.
    busy_d = (state_d == SHIFT) || (state_d == CAPTURE) || (state_d == UNLOAD);
    done_d = (state_d == DONE);
    pass_d = done_d && (sig_nxt_c == GOLDEN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      chain_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      chain_q   <= chain_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign scan_out  = chain_q[N-1];

endmodule

// File: tb/tb_param_bist_controller.sv
// Scoreboard bench for param_bist_controller: stimulus queues the expected
// end-of-run result; a monitor pops and checks it whenever done rises.
module tb_param_bist_controller;
  import bist_pkg::*;

  // Reference model of a full run with 8-bit chain (HALF_W = 4).
  function automatic logic [7:0] model_sig(input logic [7:0] seed, input int np,
                                           input logic [7:0] tl, input logic [7:0] ts);
    logic [7:0] lfsr;
    logic [7:0] chain;
    logic [7:0] sig;
    lfsr  = (seed == 8'h00) ? 8'h01 : seed;
    chain = 8'h00;
    sig   = 8'h00;
    for (int p = 0; p < np; p++) begin
      for (int i = 0; i < 8; i++) begin
        sig   = {sig[6:0], (^(sig & ts)) ^ chain[7]};
        chain = {chain[6:0], lfsr[7]};
        lfsr  = {lfsr[6:0], ^(lfsr & tl)};
      end
      chain = {4'h0, chain[7:4]} * {4'h0, chain[3:0]};
    end
    for (int i = 0; i < 8; i++) begin
      sig   = {sig[6:0], (^(sig & ts)) ^ chain[7]};
      chain = {chain[6:0], 1'b0};
    end
    return sig;
  endfunction

  localparam logic [7:0] MODEL_A = model_sig(8'h5A, 16, 8'hB8, 8'hB8);
  localparam logic [7:0] MODEL_C = model_sig(8'hFF, 1, 8'hB8, 8'hB8);

  typedef struct {
    logic [7:0] sig;
    int         cycles;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       start_c;
  logic       abort;
  logic       busy_a, done_a, pass_a, scan_a;
  logic       busy_b, done_b, pass_b, scan_b;
  logic       busy_c, done_c, pass_c, scan_c;
  logic [7:0] sig_a, sig_b, sig_c;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   start_cyc_a = 0;
  int   start_cyc_c = 0;
  exp_t q_a[$];
  exp_t q_c[$];
  logic done_a_d = 1'b0;
  logic done_c_d = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_bist_controller #(.GOLDEN(MODEL_A)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .scan_out(scan_a)
  );

  param_bist_controller #(.GOLDEN(MODEL_A + 8'd1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .scan_out(scan_b)
  );

  param_bist_controller #(.NUM_PATTERNS(1), .SEED(8'hFF), .GOLDEN(8'h00)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .abort(abort),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .scan_out(scan_c)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every done rising edge must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (done_a && !done_a_d) begin
      if (q_a.size() == 0) begin
        chk("unexpected_done_a", 32'(done_a), 32'd0);
      end else begin
        e = q_a.pop_front();
        chk("sig_a", 32'(sig_a), 32'(e.sig));
        chk("pass_a", 32'(pass_a), 32'd1);
        chk("sig_b", 32'(sig_b), 32'(e.sig));
        chk("pass_b", 32'(pass_b), 32'd0);
        chk("busy_a_in_done", 32'(busy_a), 32'd0);
        chk("run_len_a", 32'(cyc - start_cyc_a), 32'(e.cycles));
      end
    end
    if (done_c && !done_c_d) begin
      if (q_c.size() == 0) begin
        chk("unexpected_done_c", 32'(done_c), 32'd0);
      end else begin
        e = q_c.pop_front();
        chk("sig_c", 32'(sig_c), 32'(e.sig));
        chk("pass_c", 32'(pass_c), 32'(e.sig == 8'h00));
        chk("run_len_c", 32'(cyc - start_cyc_c), 32'(e.cycles));
      end
    end
    done_a_d = done_a;
    done_c_d = done_c;
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    q_a.push_back('{MODEL_A, 152});
    @(negedge clk);
    start = 1'b0;
    start_cyc_a = cyc;
  endtask

  task automatic wait_a(input int n);
    while (cyc < start_cyc_a + n) @(negedge clk);
  endtask

  task automatic drain();
    int t = 0;
    while ((q_a.size() != 0 || q_c.size() != 0) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_c", 32'(q_c.size()), 32'd0);
  endtask

  initial begin
    logic [7:0] cap_bits;
    cap_bits = 8'h32;
    rst = 1'b1; start = 1'b0; start_c = 1'b0; abort = 1'b0;
    #1;
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_pass", 32'(pass_a), 32'd0);
    chk("rst_sig", 32'(sig_a), 32'd0);
    chk("rst_scan", 32'(scan_a), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(dut_a.state_q), 32'(IDLE));

    // Single-pattern instance.
    @(negedge clk);
    start_c = 1'b1;
    q_c.push_back('{MODEL_C, 17});
    @(negedge clk);
    start_c = 1'b0;
    start_cyc_c = cyc;
    while (cyc < start_cyc_c + 8) @(negedge clk);
    chk("c_chain_loaded", 32'(dut_c.chain_q), 32'h0000_00FF);
    @(negedge clk);
    chk("c_chain_capture", 32'(dut_c.chain_q), 32'h0000_00E1);
    drain();

    // Full run with directed checks of the first pattern.
    pulse_start();
    chk("busy_rise", 32'(busy_a), 32'd1);
    wait_a(8);
    chk("chain_loaded", 32'(dut_a.chain_q), 32'h0000_005A);
    chk("state_capture", 32'(dut_a.state_q), 32'(CAPTURE));
    for (int i = 0; i < 8; i++) begin
      wait_a(9 + i);
      if (i == 0) chk("chain_capture", 32'(dut_a.chain_q), 32'h0000_0032);
      chk($sformatf("scan_out_%0d", i), 32'(scan_a), 32'(cap_bits[7-i]));
    end
    wait_a(30);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_stray_start", 32'(busy_a), 32'd1);
    drain();
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done_a), 32'd1);
    chk("sig_hold", 32'(sig_a), 32'(MODEL_A));
    chk("pass_hold", 32'(pass_a), 32'd1);

    // Back-to-back restart from DONE.
    pulse_start();
    chk("done_drop_on_restart", 32'(done_a), 32'd0);
    drain();

    // Abort during the run.
    pulse_start();
    wait_a(39);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_state", 32'(dut_a.state_q), 32'(IDLE));
    chk("abort_busy", 32'(busy_a), 32'd0);
    chk("abort_sig", 32'(sig_a), 32'd0);
    chk("abort_chain", 32'(dut_a.chain_q), 32'd0);
    chk("abort_done", 32'(done_a), 32'd0);
    q_a.delete();
    pulse_start();
    drain();

    // Asynchronous reset in the middle of UNLOAD.
    pulse_start();
    wait_a(147);
    chk("state_unload", 32'(dut_a.state_q), 32'(UNLOAD));
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    chk("arst_pass", 32'(pass_a), 32'd0);
    chk("arst_sig", 32'(sig_a), 32'd0);
    chk("arst_scan", 32'(scan_a), 32'd0);
    q_a.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("post_rst_done", 32'(done_a), 32'd0);
    chk("post_rst_busy", 32'(busy_a), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
